adder_seq_ctrl: RTL and testbench

- Multi-cycle fixed-point add/subtract controller.
- Sequences one 2-bit ripple slice (adder_block) over WIDTH-bit operands, LSB slice first, 2 bits per cycle, with a registered carry between slices.
- Sits between the ODE datapath scheduler and the accumulator registers.
- Valid/ready handshake on both sides; trades latency for area versus a full-width adder.

---
 rtl/adder_seq_ctrl.sv | 119 +++++++++++
 tb/tb_adder_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// adder_seq_ctrl : multi-cycle add/subtract, one 2-bit ripple slice per clock.
// Optional macro ADDER_SEQ_SATURATE_EN saturates o_result on signed overflow.
// Revision: 1.0
// ============================================================================
module adder_seq_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH/2)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   input  logic             i_sub,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH/2 - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_c_msb;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
`ifdef ADDER_SEQ_SATURATE_EN
   logic             r_sign_a;
`endif

   // 2-bit ripple slice; w_c1 is the carry between its two bits
   logic w_s0, w_c1, w_s1, w_c2;
   always_comb begin
      w_s0 = r_sa[0] ^ r_sb[0] ^ r_carry;
      w_c1 = (r_sa[0] & r_sb[0]) | ((r_sa[0] ^ r_sb[0]) & r_carry);
      w_s1 = r_sa[1] ^ r_sb[1] ^ w_c1;
      w_c2 = (r_sa[1] & r_sb[1]) | ((r_sa[1] ^ r_sb[1]) & w_c1);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_c_msb  <= 1'b0;
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
`ifdef ADDER_SEQ_SATURATE_EN
         r_sign_a <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  r_sa     <= i_op_a;
                  r_sb     <= i_sub ? ~i_op_b : i_op_b;
                  r_carry  <= i_sub;
                  r_cnt    <= c_cnt_load;
`ifdef ADDER_SEQ_SATURATE_EN
                  r_sign_a <= i_op_a[WIDTH-1];
`endif
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_res   <= {w_s1, w_s0, r_res[WIDTH-1:2]};
               r_sa    <= {2'b00, r_sa[WIDTH-1:2]};
               r_sb    <= {2'b00, r_sb[WIDTH-1:2]};
               r_carry <= w_c2;
               r_cnt   <= r_cnt - c_cnt_one;
               // last slice: its internal carry is the carry into the MSB
               if (r_cnt == '0) begin
                  r_c_msb <= w_c1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (i_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ready    = (r_state == S_IDLE);
   assign o_valid    = (r_state == S_DONE);
   assign o_carry    = o_valid & r_carry;
   assign o_overflow = o_valid & (r_c_msb ^ r_carry);

`ifdef ADDER_SEQ_SATURATE_EN
   always_comb begin
      o_result = r_res;
      if (o_overflow) begin
         o_result = r_sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign o_result = r_res;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_adder_seq_ctrl : directed bench for adder_seq_ctrl at WIDTH=8.
// Revision: 1.0
// ============================================================================
module tb_adder_seq_ctrl;

   localparam int WIDTH = 8;
   localparam int HALF  = WIDTH / 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [WIDTH-1:0] i_op_a = '0;
   logic [WIDTH-1:0] i_op_b = '0;
   logic             i_sub = 1'b0;
   logic             o_valid;
   logic             i_ready = 1'b0;
   logic [WIDTH-1:0] o_result;
   logic             o_carry;
   logic             o_overflow;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] m_res = '0;
   logic             m_carry = 1'b0;
   logic             m_ovf = 1'b0;
   bit               m_active = 1'b0;

   adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_op_a     (i_op_a),
      .i_op_b     (i_op_b),
      .i_sub      (i_sub),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_result   (o_result),
      .o_carry    (o_carry),
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference from signed/unsigned integer arithmetic; returns {carry, ovf, result}
   function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic sub);
      int               sa, sb, sr;
      int unsigned      ua, ub;
      logic [WIDTH-1:0] r;
      logic             c, v;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'(a);
      ub = int'(b);
      sr = sub ? (sa - sb) : (sa + sb);
      v  = (sr > (2**(WIDTH-1) - 1)) || (sr < -(2**(WIDTH-1)));
      c  = sub ? (ua >= ub) : ((ua + ub) >= 2**WIDTH);
      r  = sr[WIDTH-1:0];
`ifdef ADDER_SEQ_SATURATE_EN
      if (v) r = (sa < 0) ? WIDTH'(2**(WIDTH-1)) : WIDTH'(2**(WIDTH-1) - 1);
`endif
      return {c, v, r};
   endfunction

   // Whenever a result is presented it must match the model's pending operation
   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         checks++;
         if (!m_active || o_result !== m_res || o_carry !== m_carry ||
             o_overflow !== m_ovf || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL model_cmp: got res=0x%0h c=%0b v=%0b rdy=%0b expected res=0x%0h c=%0b v=%0b rdy=0 (pending=%0b)",
                     o_result, o_carry, o_overflow, o_ready, m_res, m_carry, m_ovf, m_active);
         end
      end
   end

   task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic sub, input logic [WIDTH-1:0] exp_r, input logic exp_c,
                         input logic exp_v, input int hold);
      logic [WIDTH+1:0] m;
      int               lat;
      m = model(a, b, sub);
      check({name, "_model"}, 32'(m), 32'({exp_c, exp_v, exp_r}));
      @(negedge clk);
      check({name, "_ready_idle"}, 32'(o_ready), 32'd1);
      i_valid = 1'b1;
      i_op_a  = a;
      i_op_b  = b;
      i_sub   = sub;
      @(posedge clk);
      m_res    = m[WIDTH-1:0];
      m_ovf    = m[WIDTH];
      m_carry  = m[WIDTH+1];
      m_active = 1'b1;
      #1;
      // garbage while busy must not disturb the operation
      i_op_a = ~a;
      i_op_b = a ^ b;
      i_sub  = ~sub;
      lat = 1;
      while (!o_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check({name, "_latency"}, 32'(lat), 32'(HALF + 1));
      check({name, "_result"}, 32'(o_result), 32'(exp_r));
      check({name, "_carry"}, 32'(o_carry), 32'(exp_c));
      check({name, "_ovf"}, 32'(o_overflow), 32'(exp_v));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         i_valid = k[0];
         i_op_a  = a ^ WIDTH'(k * 37 + 1);
         @(posedge clk);
         #1;
         check({name, "_hold_valid"}, 32'(o_valid), 32'd1);
         check({name, "_hold_ready"}, 32'(o_ready), 32'd0);
         check({name, "_hold_result"}, 32'(o_result), 32'(exp_r));
      end
      @(negedge clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      m_active = 1'b0;
      i_ready  = 1'b0;
      check({name, "_valid_drop"}, 32'(o_valid), 32'd0);
      check({name, "_ready_back"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      #1;
      check("rst_ready", 32'(o_ready), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_result", 32'(o_result), 32'd0);
      check("rst_carry", 32'(o_carry), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op("add_plain", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
      run_op("add_wrap",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 3);
`ifdef ADDER_SEQ_SATURATE_EN
      run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 3);
      run_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 0);
`else
      run_op("add_ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 3);
      run_op("sub_ovf",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
`endif
      run_op("sub_neg",   8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
      run_op("sub_zero",  8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1);

      // reset two cycles into RUN
      @(negedge clk);
      i_valid = 1'b1;
      i_op_a  = 8'h33;
      i_op_b  = 8'h11;
      i_sub   = 1'b0;
      @(posedge clk);
      #1 i_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ready", 32'(o_ready), 32'd1);
      check("midrst_valid", 32'(o_valid), 32'd0);
      check("midrst_result", 32'(o_result), 32'd0);
      check("midrst_carry", 32'(o_carry), 32'd0);
      for (int k = 0; k < HALF + 2; k++) begin
         @(posedge clk);
         #1;
         check("midrst_no_valid", 32'(o_valid), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
